async_fifo_reader: RTL and testbench

// - Read-side consumer for the team's async FIFO; lives entirely in the read clock domain.
// - Drives the FIFO read enable and absorbs the FIFO's one-cycle registered read latency.
// - Re-presents the data as a valid/ready stream with a 2-entry skid buffer.
// - Sustains 1 word/cycle under continuous m_ready and loses no word under backpressure.

---
 rtl/async_fifo_reader.sv | 93 +++++++++
 tb/tb_async_fifo_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_reader.sv
// async_fifo_reader: read-domain consumer for the async FIFO.
// Issues fifo_rd_en, absorbs the FIFO's one-cycle read latency and re-presents
// words as a valid/ready stream through a 2-entry skid buffer (head/tail).
// Optional build macro ASYNC_FIFO_READER_STATS_EN adds the rd_word_count port,
// a saturating count of delivered words.
module async_fifo_reader #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 32
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    output logic                fifo_rd_en,
    input  logic [BITS-1:0]     fifo_rd_data,
    input  logic                fifo_rd_empty,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS-1:0]     m_data
`ifdef ASYNC_FIFO_READER_STATS_EN
    ,
    output logic [CNT_BITS-1:0] rd_word_count
`endif
);

    if (BITS < 1 || CNT_BITS < 1) begin : g_bad_param
        $error("async_fifo_reader: BITS and CNT_BITS must be >= 1");
    end

    logic [1:0]      occ;
    logic            inflight;
    logic [BITS-1:0] head;
    logic [BITS-1:0] tail;
    logic            pop;
    logic [2:0]      level;
    logic            wr_tail;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;

    // Occupancy after this edge, read issue rule and capture slot selection
    always_comb begin
        pop        = m_valid && m_ready;
        level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        fifo_rd_en = !rd_rst && !fifo_rd_empty && (level < 3'd2);
        // landing slot is occ-pop: 0 = head, 1 = tail
        wr_tail    = ((occ - {1'b0, pop}) == 2'd1);
    end

    // Occupancy and outstanding-read tracking
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            occ      <= '0;
            inflight <= 1'b0;
        end else begin
            occ      <= level[1:0];
            inflight <= fifo_rd_en;
        end
    end

    // Skid buffer storage: capture returning word, shift tail to head on pop
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (inflight && !wr_tail) begin
                head <= fifo_rd_data;
            end else if (pop && occ == 2'd2) begin
                head <= tail;
            end
            if (inflight && wr_tail) begin
                tail <= fifo_rd_data;
            end
        end
    end

`ifdef ASYNC_FIFO_READER_STATS_EN
    // Saturating count of words handed downstream
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_word_count <= '0;
        end else if (pop && rd_word_count != '1) begin
            rd_word_count <= rd_word_count + 1'b1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        ({1'b0, occ} + {2'b0, inflight}) <= 3'd2);

    a_no_read_when_empty: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(fifo_rd_en && fifo_rd_empty));

endmodule

// File: tb/tb_async_fifo_reader.sv
// Scoreboard bench for async_fifo_reader: a queue-based FIFO model feeds the
// DUT, stimulus pushes expected words, a negedge monitor pops and compares.
module tb_async_fifo_reader;

    localparam int BITS     = 32;
    localparam int CNT_BITS = 8;

    logic                rd_clk = 1'b0;
    logic                rd_rst;
    logic                fifo_rd_en;
    logic [BITS-1:0]     fifo_rd_data;
    logic                fifo_rd_empty;
    logic                m_valid;
    logic                m_ready;
    logic [BITS-1:0]     m_data;
`ifdef ASYNC_FIFO_READER_STATS_EN
    logic [CNT_BITS-1:0] rd_word_count;
`endif

    async_fifo_reader #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data)
`ifdef ASYNC_FIFO_READER_STATS_EN
        ,
        .rd_word_count (rd_word_count)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int unsigned checks    = 0;
    int unsigned errors    = 0;
    int unsigned delivered = 0;

    logic [BITS-1:0] fq[$];
    logic [BITS-1:0] exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // FIFO model: registered read data, one word per accepted fifo_rd_en
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            logic [BITS-1:0] w;
            check("rd_en_while_empty", {63'd0, fq.size() == 0}, 64'd0);
            if (fq.size() != 0) begin
                w = fq.pop_front();
                fifo_rd_data  <= w;
                fifo_rd_empty <= (fq.size() == 0);
            end
        end
    end

    // Monitor: compare every handshake against the scoreboard, check stall hold
    logic            stall_prev = 1'b0;
    logic [BITS-1:0] held       = '0;
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {63'd0, m_valid}, 64'd1);
                check("hold_data", {32'd0, m_data}, {32'd0, held});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", {32'd0, m_data}, 64'hdead_0000_0000_0000);
                end else begin
                    logic [BITS-1:0] e;
                    e = exp_q.pop_front();
                    check("data", {32'd0, m_data}, {32'd0, e});
                    delivered++;
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic push_word(input logic [BITS-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_rd_empty = 1'b0;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", {63'd0, n >= budget}, 64'd0);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned d0;
        int unsigned n;

        rd_rst        = 1'b1;
        m_ready       = 1'b1;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = '0;
        for (int unsigned i = 1; i <= 16; i++) push_word(i);

        // Reset with FIFO non-empty
        tick(); tick(); tick();
        check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", {32'd0, m_data}, 64'd0);
        check("rst_fifo_kept", fq.size(), 64'd16);
        rd_rst = 1'b0;
        #1;
        check("first_rd_en", {63'd0, fifo_rd_en}, 64'd1);

        // Streaming: m_valid two edges after the first read request
        tick();
        check("lat_edge1_invalid", {63'd0, m_valid}, 64'd0);
        tick();
        check("lat_edge2_valid", {63'd0, m_valid}, 64'd1);
        for (int unsigned i = 1; i < 16; i++) begin
            tick();
            check("stream_no_gap", {63'd0, m_valid}, 64'd1);
        end
        tick();
        check("stream_done_invalid", {63'd0, m_valid}, 64'd0);
        check("stream_all_delivered", delivered, 64'd16);

        // Backpressure: 4 words queued while the sink stalls
        m_ready = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) push_word(i);
        for (int unsigned i = 0; i < 10; i++) tick();
        check("bp_valid", {63'd0, m_valid}, 64'd1);
        check("bp_data", {32'd0, m_data}, 64'd1);
        check("bp_occ", {62'd0, dut.occ}, 64'd2);
        check("bp_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        check("bp_fifo_left", fq.size(), 64'd2);

        // Release: four words on consecutive cycles
        m_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            check("release_valid", {63'd0, m_valid}, 64'd1);
            tick();
        end
        check("release_done", {63'd0, m_valid}, 64'd0);
        check("release_delivered", delivered, 64'd20);

        // Empty edge: one word, random ready, exactly one read pulse
        pulses = 0;
        d0     = delivered;
        push_word(32'hA5);
        for (int unsigned i = 0; i < 24; i++) begin
            m_ready = (i >= 18) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (fifo_rd_en) pulses++;
            tick();
        end
        check("single_rd_pulse", pulses, 64'd1);
        check("single_delivered", delivered - d0, 64'd1);
        check("single_drained", {63'd0, m_valid}, 64'd0);

`ifdef ASYNC_FIFO_READER_STATS_EN
        // Saturating word counter
        for (int unsigned i = 0; i < 300; i++) push_word(32'h100 + i);
        drain(1000);
        check("stats_saturated", {56'd0, rd_word_count}, 64'd255);
        rd_rst = 1'b1;
        #1;
        check("stats_reset", {56'd0, rd_word_count}, 64'd0);
        tick();
        rd_rst = 1'b0;
`else
        // Burst with intermittent stalls
        for (int unsigned i = 0; i < 40; i++) push_word(32'h100 + i);
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 400) begin
            m_ready = (n % 3) != 2;
            tick();
            n++;
        end
        check("burst_timeout", {63'd0, n >= 400}, 64'd0);
        m_ready = 1'b1;
`endif

        check("scoreboard_empty", exp_q.size(), 64'd0);
        rd_rst = 1'b1;
        #1;
        check("final_rst_valid", {63'd0, m_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
